fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I pipeline. It holds the program counter, drives the instruction-memory address, selects between PC+4 and the execute-stage redirect target, and captures the fetched instruction into the decode-stage register. It consumes the hazard unit's stallF, stallD and flushD controls, and keeps saturating stall and flush event counters for debug and performance visibility.

---
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register of a 5-stage
//   RV32I pipeline. Holds pcF, drives the instruction-memory address, chooses
//   between the sequential PC and the execute-stage redirect, and captures the
//   fetched word into the decode-stage register. Saturating stall/flush event
//   counters give debug and performance visibility.
//
// Ports
//   clk, rst                    : clock, async active-high reset
//   stallF, stallD, flushD      : hazard-unit controls
//   pc_srcE, pc_targetE         : redirect request and target from execute
//   imem_addr / imem_rdata      : instruction-memory address / combinational data
//   instrD, pcD, pc_plus4D      : decode-stage instruction and its PCs
//   validD                      : instrD is a real fetch (not a bubble)
//   misalign_err                : sticky, a redirect target had nonzero [1:0]
//   stall_cnt, flush_cnt        : saturating event counters
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             pc_srcE,
  input  logic [XLEN-1:0]  pc_targetE,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instrD,
  output logic [XLEN-1:0]  pcD,
  output logic [XLEN-1:0]  pc_plus4D,
  output logic             validD,
  output logic             misalign_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [XLEN-1:0]  r_pcF;
  logic [31:0]      r_instrD;
  logic [XLEN-1:0]  r_pcD;
  logic [XLEN-1:0]  r_pc_plus4D;
  logic             r_validD;
  logic             r_misalign;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [XLEN-1:0]  w_pc_plus4F;
  logic [XLEN-1:0]  w_redirect_pc;

  // Natural XLEN-bit overflow gives the wrap from the top word back to 0.
  assign w_pc_plus4F   = r_pcF + XLEN'(4);
  // A misaligned target is still followed, just word-aligned.
  assign w_redirect_pc = {pc_targetE[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcF       <= RESET_PC;
      r_instrD    <= NOP_INSTR;
      r_pcD       <= '0;
      r_pc_plus4D <= '0;
      r_validD    <= 1'b0;
      r_misalign  <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      // Redirect beats stallF so a taken branch is never dropped.
      if (pc_srcE)      r_pcF <= w_redirect_pc;
      else if (!stallF) r_pcF <= w_pc_plus4F;

      // Flush beats stallD: a squashed slot must become a bubble.
      if (flushD) begin
        r_instrD    <= NOP_INSTR;
        r_pcD       <= '0;
        r_pc_plus4D <= '0;
        r_validD    <= 1'b0;
      end else if (!stallD) begin
        r_instrD    <= imem_rdata;
        r_pcD       <= r_pcF;
        r_pc_plus4D <= w_pc_plus4F;
        r_validD    <= 1'b1;
      end

      if (pc_srcE && (pc_targetE[1:0] != 2'b00)) r_misalign <= 1'b1;

      if (stallF && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flushD && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign imem_addr    = r_pcF;
  assign instrD       = r_instrD;
  assign pcD          = r_pcD;
  assign pc_plus4D    = r_pc_plus4D;
  assign validD       = r_validD;
  assign misalign_err = r_misalign;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             stallF, stallD, flushD, pc_srcE;
  logic [31:0]      pc_targetE;
  logic [31:0]      imem_addr, imem_rdata;
  logic [31:0]      instrD, pcD, pc_plus4D;
  logic             validD, misalign_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic [31:0] mem [0:255];
  assign imem_rdata = mem[imem_addr[9:2]];

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0000_0013), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .pc_srcE(pc_srcE), .pc_targetE(pc_targetE), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instrD(instrD), .pcD(pcD), .pc_plus4D(pc_plus4D),
    .validD(validD), .misalign_err(misalign_err), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state, stepped once per rising edge from the spec's rules.
  logic [31:0] m_pc, m_instr, m_pcD, m_pc4D;
  logic        m_valid, m_mis;
  int          m_scnt, m_fcnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = 32'h0; m_instr = 32'h13; m_pcD = 0; m_pc4D = 0;
    m_valid = 0; m_mis = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic m_edge();
    logic [31:0] fetched;
    if (rst) begin m_reset(); return; end
    fetched = mem[m_pc[9:2]];
    if (flushD) begin
      m_instr = 32'h13; m_pcD = 0; m_pc4D = 0; m_valid = 0;
    end else if (!stallD) begin
      m_instr = fetched; m_pcD = m_pc; m_pc4D = m_pc + 32'd4; m_valid = 1;
    end
    if (pc_srcE && pc_targetE[1:0] != 2'b00) m_mis = 1;
    if (stallF && m_scnt < CMAX) m_scnt++;
    if (flushD && m_fcnt < CMAX) m_fcnt++;
    if (pc_srcE)      m_pc = pc_targetE & 32'hFFFF_FFFC;
    else if (!stallF) m_pc = m_pc + 32'd4;
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("instrD", instrD, m_instr);
    chk("pcD", pcD, m_pcD);
    chk("pc_plus4D", pc_plus4D, m_pc4D);
    chk("validD", {31'b0, validD}, {31'b0, m_valid});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
    chk("stall_cnt", {16'b0, stall_cnt}, m_scnt[31:0]);
    chk("flush_cnt", {16'b0, flush_cnt}, m_fcnt[31:0]);
  endtask

  task automatic cyc();
    @(posedge clk);
    m_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic sf, input logic sd, input logic fd,
                       input logic ps, input logic [31:0] tgt);
    stallF = sf; stallD = sd; flushD = fd; pc_srcE = ps; pc_targetE = tgt;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h00A0_0093;
    mem[1] = 32'h0010_0113;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    m_reset();
    #1;
    check_all();
    chk("reset_instrD_nop", instrD, 32'h0000_0013);
    @(negedge clk);
    rst = 1'b0;

    // Free-running fetch from RESET_PC.
    cyc();
    chk("first_instrD", instrD, 32'h00A0_0093);
    chk("first_valid", {31'b0, validD}, 32'd1);
    cyc();
    chk("second_instrD", instrD, 32'h0010_0113);

    // Load-use stall for two cycles at pcF=0x8.
    drive(1, 1, 0, 0, 0);
    cyc(); cyc();
    chk("stall_pc_hold", imem_addr, 32'h8);
    chk("stall_pcD_hold", pcD, 32'h4);
    chk("stall_cnt_two", {16'b0, stall_cnt}, 32'd2);
    drive(0, 0, 0, 0, 0);
    cyc();
    chk("stall_release", imem_addr, 32'hC);
    cyc();

    // Redirect to 0x40 with flush, from pcF=0x10.
    chk("pre_redirect_pc", imem_addr, 32'h10);
    drive(0, 0, 1, 1, 32'h40);
    cyc();
    chk("redir_pc", imem_addr, 32'h40);
    chk("redir_bubble", instrD, 32'h13);
    drive(0, 0, 0, 0, 0);
    cyc();
    chk("redir_pcD", pcD, 32'h40);
    chk("flush_cnt_one", {16'b0, flush_cnt}, 32'd1);

    // Misaligned target, then later aligned redirects; redirect beats stallF.
    drive(0, 0, 1, 1, 32'h42);
    cyc();
    chk("misalign_pc", imem_addr, 32'h40);
    chk("misalign_set", {31'b0, misalign_err}, 32'd1);
    drive(1, 0, 0, 1, 32'h80);
    cyc();
    chk("redir_over_stall", imem_addr, 32'h80);
    drive(0, 0, 0, 0, 0);
    cyc(); cyc();

    // PC wrap from the top word to zero.
    drive(0, 0, 1, 1, 32'hFFFF_FFF8);
    cyc();
    drive(0, 0, 0, 0, 0);
    cyc();
    chk("top_word", imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_zero", imem_addr, 32'h0);
    chk("wrap_plus4D", pc_plus4D, 32'h0);
    cyc();

    // Counter saturation.
    drive(1, 1, 0, 0, 0);
    repeat (CMAX + 4) cyc();
    chk("stall_sat", {16'b0, stall_cnt}, 32'hFFFF);

    // flushD together with stallD loads a bubble.
    drive(1, 1, 1, 0, 0);
    cyc();
    chk("flush_over_stall", {31'b0, validD}, 32'd0);
    drive(0, 0, 0, 0, 0);
    cyc(); cyc();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic ps;
      ps = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            ps | ($urandom_range(0, 11) == 0), ps,
            {22'b0, $urandom_range(0, 1023)} & ($urandom_range(0, 3) == 0 ? 32'h3FF : 32'h3FC));
      cyc();
    end

    // Async reset mid-cycle with pcF=0x80 and nonzero counters.
    drive(0, 0, 1, 1, 32'h80);
    cyc();
    drive(1, 1, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    check_all();
    chk("async_rst_pc", imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("restart_pcD", pcD, 32'h0);
    chk("restart_pc", imem_addr, 32'h4);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
